// File: rtl/adder_batch_sequencer.sv
// adder_batch_sequencer: buffers a batch of operand pairs from the RX UART,
// runs each pair through the adder datapath, streams results to the TX UART.
module adder_batch_sequencer #(
  parameter int DEPTH = 8
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [7:0]  Rx_Byte_in,
  input  logic        Rx_DV_in,
  input  logic        Tx_Done_in,
  output logic        Tx_DV_out,
  output logic [7:0]  Tx_Byte_out,
  output logic        En_out,
  output logic [15:0] a_out,
  output logic [15:0] b_out,
  input  logic [15:0] c_in,
  input  logic        c_valid_in,
  output logic        Busy_out,
  output logic        Err_out
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [7:0] MAX_N = 8'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ISSUE,
    S_WAIT,
    S_TX_MSB,
    S_TX_MSB_WAIT,
    S_TX_LSB,
    S_TX_LSB_WAIT
  } state_t;

  state_t state, state_nxt;

  logic [3:0]    n;
  logic [3:0]    idx;
  logic [1:0]    bsel;
  logic [AW-1:0] ptr;
  logic          last;
  logic          cnt_ok;
  logic          err;

  logic [15:0] a_mem [DEPTH];
  logic [15:0] b_mem [DEPTH];
  logic [15:0] r_mem [DEPTH];

  logic [15:0] a_hold;
  logic [15:0] b_hold;
  logic [7:0]  tx_hold;

  assign ptr    = idx[AW-1:0];
  assign last   = (idx == n - 4'd1);
  assign cnt_ok = (Rx_Byte_in != 8'd0) && (Rx_Byte_in <= MAX_N);
  assign Err_out = err;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= S_IDLE;
      n       <= '0;
      idx     <= '0;
      bsel    <= '0;
      err     <= 1'b0;
      a_hold  <= '0;
      b_hold  <= '0;
      tx_hold <= '0;
    end else begin
      state <= state_nxt;
      unique case (state)
        S_IDLE: begin
          if (Rx_DV_in) begin
            if (cnt_ok) begin
              n    <= Rx_Byte_in[3:0];
              err  <= 1'b0;
              idx  <= '0;
              bsel <= '0;
            end else begin
              err <= 1'b1;
            end
          end
        end
        S_LOAD: begin
          if (Rx_DV_in) begin
            bsel <= bsel + 2'd1;
            if (bsel == 2'd3)
              idx <= last ? 4'd0 : idx + 4'd1;
          end
        end
        S_ISSUE: begin
          a_hold <= a_mem[ptr];
          b_hold <= b_mem[ptr];
        end
        S_WAIT: begin
          if (c_valid_in)
            idx <= last ? 4'd0 : idx + 4'd1;
        end
        S_TX_MSB: tx_hold <= r_mem[ptr][15:8];
        S_TX_LSB: tx_hold <= r_mem[ptr][7:0];
        S_TX_LSB_WAIT: begin
          if (Tx_Done_in && !last)
            idx <= idx + 4'd1;
        end
        default: ;
      endcase
    end
  end

  // Buffers carry no reset; their contents are don't-care until written.
  always_ff @(posedge CLK) begin
    if (state == S_LOAD && Rx_DV_in) begin
      unique case (bsel)
        2'd0: a_mem[ptr][15:8] <= Rx_Byte_in;
        2'd1: a_mem[ptr][7:0]  <= Rx_Byte_in;
        2'd2: b_mem[ptr][15:8] <= Rx_Byte_in;
        2'd3: b_mem[ptr][7:0]  <= Rx_Byte_in;
        default: ;
      endcase
    end
    if (state == S_WAIT && c_valid_in)
      r_mem[ptr] <= c_in;
  end

  always_comb begin
    state_nxt   = state;
    En_out      = 1'b0;
    Tx_DV_out   = 1'b0;
    Busy_out    = (state != S_IDLE);
    a_out       = a_hold;
    b_out       = b_hold;
    Tx_Byte_out = tx_hold;
    unique case (state)
      S_IDLE: begin
        if (Rx_DV_in && cnt_ok)
          state_nxt = S_LOAD;
      end
      S_LOAD: begin
        if (Rx_DV_in && bsel == 2'd3 && last)
          state_nxt = S_ISSUE;
      end
      S_ISSUE: begin
        En_out    = 1'b1;
        a_out     = a_mem[ptr];
        b_out     = b_mem[ptr];
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (c_valid_in)
          state_nxt = last ? S_TX_MSB : S_ISSUE;
      end
      S_TX_MSB: begin
        Tx_DV_out   = 1'b1;
        Tx_Byte_out = r_mem[ptr][15:8];
        state_nxt   = S_TX_MSB_WAIT;
      end
      S_TX_MSB_WAIT: begin
        if (Tx_Done_in)
          state_nxt = S_TX_LSB;
      end
      S_TX_LSB: begin
        Tx_DV_out   = 1'b1;
        Tx_Byte_out = r_mem[ptr][7:0];
        state_nxt   = S_TX_LSB_WAIT;
      end
      S_TX_LSB_WAIT: begin
        if (Tx_Done_in)
          state_nxt = last ? S_IDLE : S_TX_MSB;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_adder_batch_sequencer.sv
// tb_adder_batch_sequencer: directed batches against small datapath
// and TX UART models; expected bytes are computed by hand.
module tb_adder_batch_sequencer;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [7:0]  Rx_Byte_in = '0;
  logic        Rx_DV_in = 1'b0;
  logic        Tx_Done_in;
  logic        Tx_DV_out;
  logic [7:0]  Tx_Byte_out;
  logic        En_out;
  logic [15:0] a_out;
  logic [15:0] b_out;
  logic [15:0] c_in = '0;
  logic        c_valid_in = 1'b0;
  logic        Busy_out;
  logic        Err_out;

  logic tx_done_m = 1'b0;
  logic spur_tx = 1'b0;
  assign Tx_Done_in = tx_done_m | spur_tx;

  adder_batch_sequencer #(.DEPTH(8)) dut (
    .CLK(CLK),
    .RST(RST),
    .Rx_Byte_in(Rx_Byte_in),
    .Rx_DV_in(Rx_DV_in),
    .Tx_Done_in(Tx_Done_in),
    .Tx_DV_out(Tx_DV_out),
    .Tx_Byte_out(Tx_Byte_out),
    .En_out(En_out),
    .a_out(a_out),
    .b_out(b_out),
    .c_in(c_in),
    .c_valid_in(c_valid_in),
    .Busy_out(Busy_out),
    .Err_out(Err_out)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // Datapath model: A+B mod 2^16 after lat cycles.
  int          lat = 1;
  int          dp_cnt = 0;
  logic        spur_c = 1'b0;
  logic [15:0] da = '0;
  logic [15:0] db = '0;
  int          en_count = 0;
  int          en_cyc [64];

  always @(negedge CLK) begin
    c_valid_in = 1'b0;
    if (dp_cnt > 0) begin
      dp_cnt = dp_cnt - 1;
      if (dp_cnt == 0) begin
        c_valid_in = 1'b1;
        c_in = da + db;
      end
    end
    if (En_out) begin
      if (en_count < 64) en_cyc[en_count] = cyc;
      en_count = en_count + 1;
      da = a_out;
      db = b_out;
      dp_cnt = lat;
      if (spur_c) begin
        c_valid_in = 1'b1;
        c_in = 16'hDEAD;
      end
    end
  end

  // TX UART model: records bytes, answers Tx_Done after tx_delay.
  logic [7:0] txq [$];
  int   tx_delay = 2;
  int   tx_cnt = 0;
  int   width_err = 0;
  logic prev_dv = 1'b0;

  always @(negedge CLK) begin
    tx_done_m = 1'b0;
    if (tx_cnt > 0) begin
      tx_cnt = tx_cnt - 1;
      if (tx_cnt == 0) tx_done_m = 1'b1;
    end
    if (Tx_DV_out) begin
      txq.push_back(Tx_Byte_out);
      tx_cnt = tx_delay;
      if (prev_dv) width_err = width_err + 1;
    end
    prev_dv = Tx_DV_out;
  end

  int passed = 0;
  int total = 0;
  int failed = 0;

  logic [15:0] pa [16];
  logic [15:0] pb [16];
  logic [7:0]  exp_tx [32];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] v);
    @(negedge CLK);
    Rx_Byte_in = v;
    Rx_DV_in = 1'b1;
    @(negedge CLK);
    Rx_DV_in = 1'b0;
  endtask

  task automatic send_pairs(input int n);
    for (int k = 0; k < n; k++) begin
      send(pa[k][15:8]);
      send(pa[k][7:0]);
      send(pb[k][15:8]);
      send(pb[k][7:0]);
    end
  endtask

  task automatic wait_idle();
    int k = 0;
    while (Busy_out && k < 3000) begin
      @(negedge CLK);
      k++;
    end
    chk("idle_timeout", (k < 3000) ? 32'd1 : 32'd0, 32'd1);
  endtask

  task automatic chk_tx(input string tag, input int base, input int nb);
    chk({tag, "_count"}, 32'(txq.size() - base), 32'(nb));
    for (int j = 0; j < nb; j++)
      if (base + j < txq.size())
        chk(tag, 32'(txq[base + j]), 32'(exp_tx[j]));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0;
    int t0;
    int k;

    // Reset state
    repeat (3) @(negedge CLK);
    chk("rst_busy", 32'(Busy_out), 32'd0);
    chk("rst_err", 32'(Err_out), 32'd0);
    chk("rst_en", 32'(En_out), 32'd0);
    chk("rst_txdv", 32'(Tx_DV_out), 32'd0);
    chk("rst_txbyte", 32'(Tx_Byte_out), 32'd0);
    chk("rst_a", 32'(a_out), 32'd0);
    chk("rst_b", 32'(b_out), 32'd0);
    RST = 1'b0;

    // Single pair, latency 1
    lat = 1;
    tx_delay = 2;
    e0 = en_count;
    t0 = txq.size();
    pa[0] = 16'h0100;
    pb[0] = 16'h0080;
    send(8'd1);
    chk("t1_busy_after_count", 32'(Busy_out), 32'd1);
    send_pairs(1);
    chk("t1_en", 32'(En_out), 32'd1);
    chk("t1_a", 32'(a_out), 32'h0100);
    chk("t1_b", 32'(b_out), 32'h0080);
    wait_idle();
    chk("t1_busy_end", 32'(Busy_out), 32'd0);
    chk("t1_en_pulses", 32'(en_count - e0), 32'd1);
    chk("t1_a_hold", 32'(a_out), 32'h0100);
    exp_tx[0] = 8'h01;
    exp_tx[1] = 8'h80;
    chk_tx("t1_tx", t0, 2);

    // Three pairs with wraparound, latency 3
    lat = 3;
    e0 = en_count;
    t0 = txq.size();
    pa[0] = 16'h7FFF; pb[0] = 16'h0001;
    pa[1] = 16'hFFF8; pb[1] = 16'h0008;
    pa[2] = 16'h8000; pb[2] = 16'hFFFF;
    send(8'd3);
    send_pairs(3);
    chk("t2_en", 32'(En_out), 32'd1);
    wait_idle();
    chk("t2_en_pulses", 32'(en_count - e0), 32'd3);
    chk("t2_gap01", 32'(en_cyc[e0 + 1] - en_cyc[e0]), 32'd4);
    chk("t2_gap12", 32'(en_cyc[e0 + 2] - en_cyc[e0 + 1]), 32'd4);
    exp_tx[0] = 8'h80; exp_tx[1] = 8'h00;
    exp_tx[2] = 8'h00; exp_tx[3] = 8'h00;
    exp_tx[4] = 8'h7F; exp_tx[5] = 8'hFF;
    chk_tx("t2_tx", t0, 6);

    // Bad counts then a good one
    t0 = txq.size();
    send(8'h00);
    chk("t3_err_zero", 32'(Err_out), 32'd1);
    chk("t3_idle_zero", 32'(Busy_out), 32'd0);
    send(8'h09);
    chk("t3_err_nine", 32'(Err_out), 32'd1);
    chk("t3_idle_nine", 32'(Busy_out), 32'd0);
    send(8'h01);
    chk("t3_err_clear", 32'(Err_out), 32'd0);
    chk("t3_load", 32'(Busy_out), 32'd1);
    pa[0] = 16'h1234;
    pb[0] = 16'h0001;
    send_pairs(1);
    wait_idle();
    exp_tx[0] = 8'h12;
    exp_tx[1] = 8'h35;
    chk_tx("t3_tx", t0, 2);

    // Slow TX and spurious pulses during ISSUE/WAIT
    lat = 3;
    tx_delay = 20;
    spur_c = 1'b1;
    e0 = en_count;
    t0 = txq.size();
    pa[0] = 16'h1111; pb[0] = 16'h2222;
    pa[1] = 16'hA0A0; pb[1] = 16'h0505;
    send(8'd2);
    send_pairs(2);
    chk("t4_en", 32'(En_out), 32'd1);
    Rx_Byte_in = 8'h02;
    Rx_DV_in = 1'b1;
    spur_tx = 1'b1;
    @(negedge CLK);
    Rx_Byte_in = 8'h01;
    @(negedge CLK);
    Rx_DV_in = 1'b0;
    spur_tx = 1'b0;
    wait_idle();
    spur_c = 1'b0;
    chk("t4_en_pulses", 32'(en_count - e0), 32'd2);
    chk("t4_err", 32'(Err_out), 32'd0);
    chk("t4_width", 32'(width_err), 32'd0);
    exp_tx[0] = 8'h33; exp_tx[1] = 8'h33;
    exp_tx[2] = 8'hA5; exp_tx[3] = 8'hA5;
    chk_tx("t4_tx", t0, 4);
    repeat (3) @(negedge CLK);
    chk("t4_stay_idle", 32'(Busy_out), 32'd0);

    // Reset while waiting on pair 1 of four
    lat = 3;
    tx_delay = 1;
    t0 = txq.size();
    for (int j = 0; j < 4; j++) begin
      pa[j] = 16'(j + 1);
      pb[j] = 16'h0001;
    end
    send(8'd4);
    send_pairs(4);
    k = 0;
    do begin
      @(negedge CLK);
      k++;
    end while (!En_out && k < 100);
    chk("t5_second_issue", (k < 100) ? 32'd1 : 32'd0, 32'd1);
    chk("t5_a_pair1", 32'(a_out), 32'h0002);
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    chk("t5_rst_busy", 32'(Busy_out), 32'd0);
    chk("t5_rst_en", 32'(En_out), 32'd0);
    chk("t5_rst_txdv", 32'(Tx_DV_out), 32'd0);
    chk("t5_rst_txbyte", 32'(Tx_Byte_out), 32'd0);
    chk("t5_rst_a", 32'(a_out), 32'd0);
    chk("t5_rst_b", 32'(b_out), 32'd0);
    chk("t5_rst_err", 32'(Err_out), 32'd0);
    RST = 1'b0;
    repeat (4) @(negedge CLK);
    chk("t5_no_partial", 32'(txq.size() - t0), 32'd0);
    t0 = txq.size();
    pa[0] = 16'h00FF;
    pb[0] = 16'h0001;
    send(8'd1);
    send_pairs(1);
    wait_idle();
    exp_tx[0] = 8'h01;
    exp_tx[1] = 8'h00;
    chk_tx("t5_tx", t0, 2);

    // Full depth
    lat = 1;
    tx_delay = 1;
    e0 = en_count;
    t0 = txq.size();
    for (int j = 0; j < 8; j++) begin
      pa[j] = 16'(j);
      pb[j] = 16'(j) << 8;
      exp_tx[2 * j] = 8'(j);
      exp_tx[2 * j + 1] = 8'(j);
    end
    send(8'd8);
    send_pairs(8);
    wait_idle();
    chk("t6_en_pulses", 32'(en_count - e0), 32'd8);
    chk_tx("t6_tx", t0, 16);
    chk("width_total", 32'(width_err), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
